// File: rtl/scan_ctrl_pkg.sv
// Shared encodings for the scan chain master.
// Command opcodes and controller FSM states.
package scan_ctrl_pkg;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_XFER  = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    RST,
    CAP_P,
    CAP_G1,
    CAP_N,
    CAP_G2,
    SH_SETUP,
    SH_P,
    SH_MID,
    SH_N,
    UPD_G,
    UPD,
    DONE
  } state_t;

  function automatic logic has_capture(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_XFER);
  endfunction

  function automatic logic has_update(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_XFER);
  endfunction

endpackage

// File: rtl/scan_phase_timer.sv
// Loadable down-counter shared by all timed FSM states.
// tc is high while the count sits at zero.
module scan_phase_timer #(
  parameter int Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             tc
);

  logic [Width-1:0] cnt;

  // Reload on state entry, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/scan_chain_master.sv
// Two-phase scan chain sequencer: reset, capture, shift and update.
// One command at a time through a valid/ready handshake.
module scan_chain_master #(
  parameter int ChainLength = 104,
  parameter int HalfPeriod  = 2,
  parameter int ResetCycles = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   CmdValid,
  output logic                   CmdReady,
  input  logic [1:0]             CmdOp,
  input  logic [ChainLength-1:0] TxData,
  output logic [ChainLength-1:0] RxData,
  output logic                   Done,
  output logic                   SClkP,
  output logic                   SClkN,
  output logic                   SEnable,
  output logic                   SUpdate,
  output logic                   SReset,
  output logic                   SIn,
  input  logic                   SOut
);

  import scan_ctrl_pkg::*;

  localparam int MaxCnt = (HalfPeriod > ResetCycles) ?
                          HalfPeriod : ResetCycles;
  localparam int TW = $clog2(MaxCnt + 1);
  localparam int BW = $clog2(ChainLength + 1);

  localparam logic [TW-1:0] HalfLoad = TW'(HalfPeriod - 1);
  localparam logic [TW-1:0] RstLoad  = TW'(ResetCycles - 1);
  localparam logic [BW-1:0] LastBit  = BW'(ChainLength - 1);

  state_t                 state;
  logic [1:0]             op;
  logic [ChainLength-1:0] sr;
  logic [BW-1:0]          bit_cnt;
  logic                   timed;
  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tc;

  // Timer reloads whenever the FSM is about to change state
  always_comb begin
    timed    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = HalfLoad;
    timed = (state == RST)  || (state == CAP_P) ||
            (state == CAP_N) || (state == SH_P) ||
            (state == SH_N) || (state == UPD);
    if (timed) begin
      tmr_load = tc;
    end else begin
      tmr_load = (state != IDLE) || CmdValid;
    end
    if (state == IDLE && CmdOp == OP_RESET) begin
      tmr_val = RstLoad;
    end
  end

  scan_phase_timer #(
    .Width (TW)
  ) u_timer (
    .clk      (Clk),
    .rst      (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  // Controller FSM; every output is set on entry to its state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      op       <= OP_RESET;
      sr       <= '0;
      bit_cnt  <= '0;
      CmdReady <= 1'b1;
      Done     <= 1'b0;
      SClkP    <= 1'b0;
      SClkN    <= 1'b0;
      SEnable  <= 1'b0;
      SUpdate  <= 1'b0;
      SReset   <= 1'b0;
      SIn      <= 1'b0;
      RxData   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (CmdValid) begin
            op       <= CmdOp;
            CmdReady <= 1'b0;
            sr       <= (CmdOp == OP_WRITE) ? (TxData >> 1) : TxData;
            case (CmdOp)
              OP_RESET: begin
                state  <= RST;
                SReset <= 1'b1;
              end
              OP_WRITE: begin
                state   <= SH_SETUP;
                SEnable <= 1'b1;
                SIn     <= TxData[0];
                bit_cnt <= '0;
              end
              default: begin
                state <= CAP_P;
                SClkP <= 1'b1;
              end
            endcase
          end
        end
        RST: begin
          if (tc) begin
            SReset <= 1'b0;
            Done   <= 1'b1;
            state  <= DONE;
          end
        end
        CAP_P: begin
          if (tc) begin
            SClkP <= 1'b0;
            state <= CAP_G1;
          end
        end
        CAP_G1: begin
          SClkN <= 1'b1;
          state <= CAP_N;
        end
        CAP_N: begin
          if (tc) begin
            SClkN <= 1'b0;
            state <= CAP_G2;
          end
        end
        CAP_G2: begin
          SEnable <= 1'b1;
          SIn     <= sr[0];
          sr      <= sr >> 1;
          bit_cnt <= '0;
          state   <= SH_SETUP;
        end
        SH_SETUP: begin
          if (has_capture(op)) begin
            RxData <= (RxData >> 1) |
                      (ChainLength'(SOut) << (ChainLength - 1));
          end
          SClkP <= 1'b1;
          state <= SH_P;
        end
        SH_P: begin
          if (tc) begin
            SClkP <= 1'b0;
            state <= SH_MID;
          end
        end
        SH_MID: begin
          SClkN <= 1'b1;
          state <= SH_N;
        end
        SH_N: begin
          if (tc) begin
            SClkN <= 1'b0;
            if (bit_cnt == LastBit) begin
              SEnable <= 1'b0;
              if (has_update(op)) begin
                state <= UPD_G;
              end else begin
                Done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              SIn     <= sr[0];
              sr      <= sr >> 1;
              state   <= SH_SETUP;
            end
          end
        end
        UPD_G: begin
          SUpdate <= 1'b1;
          state   <= UPD;
        end
        UPD: begin
          if (tc) begin
            SUpdate <= 1'b0;
            Done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          Done     <= 1'b0;
          CmdReady <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_master.sv
// Randomized bench for scan_chain_master with a behavioural
// two-phase scan chain, capture input and update latch attached.
module tb_scan_chain_master;

  localparam int N  = 8;
  localparam int H  = 1;
  localparam int RC = 3;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_XFER  = 2'd3;

  logic         Clk;
  logic         Reset;
  logic         CmdValid;
  logic         CmdReady;
  logic [1:0]   CmdOp;
  logic [N-1:0] TxData;
  logic [N-1:0] RxData;
  logic         Done;
  logic         SClkP;
  logic         SClkN;
  logic         SEnable;
  logic         SUpdate;
  logic         SReset;
  logic         SIn;
  logic         SOut;

  scan_chain_master #(
    .ChainLength (N),
    .HalfPeriod  (H),
    .ResetCycles (RC)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdOp    (CmdOp),
    .TxData   (TxData),
    .RxData   (RxData),
    .Done     (Done),
    .SClkP    (SClkP),
    .SClkN    (SClkN),
    .SEnable  (SEnable),
    .SUpdate  (SUpdate),
    .SReset   (SReset),
    .SIn      (SIn),
    .SOut     (SOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural chain: master latches on SClkP, slave on SClkN
  logic [N-1:0] ch = '0;
  logic [N-1:0] m_vec = '0;
  logic         m_bit = 1'b0;
  logic [N-1:0] latch = '0;
  logic [N-1:0] cap_in = '0;
  logic         pp = 1'b0, pn = 1'b0, pu = 1'b0, pr = 1'b0;
  int           last_ph = 0;
  bit           gap = 1'b1;
  int           overlap = 0, nogap = 0;
  int           sreset_hi = 0, supd_hi = 0, done_cnt = 0;
  logic         sin_q[$];

  assign SOut = ch[0];

  always @(negedge Clk) begin
    if (SClkP && !pp) begin
      if (SEnable) begin
        m_bit = SIn;
        sin_q.push_back(SIn);
      end else begin
        m_vec = cap_in;
      end
    end
    if (SClkN && !pn) begin
      ch = SEnable ? {m_bit, ch[N-1:1]} : m_vec;
    end
    if (SUpdate && !pu) latch = ch;
    if (SReset && !pr) ch = '0;
    if (SClkP && SClkN) overlap++;
    if (SClkP) begin
      if (last_ph == 2 && !gap) nogap++;
      last_ph = 1;
      gap = 1'b0;
    end else if (SClkN) begin
      if (last_ph == 1 && !gap) nogap++;
      last_ph = 2;
      gap = 1'b0;
    end else begin
      gap = 1'b1;
    end
    if (SReset) sreset_hi++;
    if (SUpdate) supd_hi++;
    if (Done) done_cnt++;
    pp = SClkP;
    pn = SClkN;
    pu = SUpdate;
    pr = SReset;
  end

  logic [N-1:0] lat_exp = '0;
  logic [N-1:0] rx_exp = '0;

  task automatic clear_mon();
    overlap = 0;
    nogap = 0;
    sreset_hi = 0;
    supd_hi = 0;
    done_cnt = 0;
    sin_q.delete();
  endtask

  function automatic int exp_latency(input logic [1:0] op);
    int shift_c, cap_c, upd_c;
    if (op == OP_RESET) return RC;
    shift_c = N * (2 * H + 2);
    cap_c = (op == OP_READ || op == OP_XFER) ? 2 * H + 2 : 0;
    upd_c = (op == OP_WRITE || op == OP_XFER) ? H + 1 : 0;
    return shift_c + cap_c + upd_c;
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (!Done && lat < 200) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op,
                         input logic [N-1:0] tx,
                         input logic [N-1:0] cap);
    int lat, n;
    logic [N-1:0] sb;
    cap_in = cap;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!CmdReady && n < 200);
    chk("ready_wait", 32'(CmdReady), 1);
    CmdOp = op;
    TxData = tx;
    CmdValid = 1'b1;
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
    clear_mon();
    chk("busy", 32'(CmdReady), 0);
    wait_done(lat);
    chk("latency", lat, exp_latency(op));
    chk("ready_at_done", 32'(CmdReady), 0);
    if (op == OP_RESET) chk("sreset_len", sreset_hi, RC);
    else chk("sreset_idle", sreset_hi, 0);
    if (op == OP_WRITE || op == OP_XFER) begin
      sb = '0;
      for (int k = 0; k < sin_q.size() && k < N; k++) sb[k] = sin_q[k];
      chk("sin_count", sin_q.size(), N);
      chk("sin_seq", 32'(sb), 32'(tx));
      chk("supd_len", supd_hi, H);
      lat_exp = tx;
    end else begin
      chk("supd_idle", supd_hi, 0);
    end
    if (op == OP_READ || op == OP_XFER) rx_exp = cap;
    chk("rxdata", 32'(RxData), 32'(rx_exp));
    chk("latch", 32'(latch), 32'(lat_exp));
    chk("overlap", overlap, 0);
    chk("phase_gap", nogap, 0);
    @(posedge Clk);
    #1;
    chk("done_pulse", 32'(Done), 0);
    chk("ready_after", 32'(CmdReady), 1);
  endtask

  initial begin
    int lat, n;
    logic [N-1:0] tx2;
    Reset = 1'b1;
    CmdValid = 1'b0;
    CmdOp = OP_RESET;
    TxData = '0;
    repeat (2) @(negedge Clk);
    chk("rst_ready", 32'(CmdReady), 1);
    chk("rst_outs", 32'({Done, SClkP, SClkN, SEnable,
                          SUpdate, SReset, SIn}), 0);
    chk("rst_rx", 32'(RxData), 0);
    Reset = 1'b0;

    run_cmd(OP_RESET, 8'($urandom), 8'($urandom));
    run_cmd(OP_WRITE, 8'hA5, 8'($urandom));
    run_cmd(OP_READ, 8'($urandom), 8'h3C);
    run_cmd(OP_XFER, 8'hFF, 8'h00);

    // Back-to-back with CmdValid held through a busy READ
    cap_in = 8'h5A;
    tx2 = 8'hC3;
    @(negedge Clk);
    CmdOp = OP_READ;
    TxData = 8'($urandom);
    CmdValid = 1'b1;
    @(posedge Clk);
    #1;
    clear_mon();
    CmdOp = OP_WRITE;
    TxData = tx2;
    wait_done(lat);
    chk("b2b_read_lat", lat, exp_latency(OP_READ));
    chk("b2b_rx", 32'(RxData), 32'h5A);
    chk("b2b_latch", 32'(latch), 32'(lat_exp));
    chk("b2b_supd", supd_hi, 0);
    rx_exp = 8'h5A;
    @(posedge Clk);
    #1;
    chk("b2b_ready", 32'(CmdReady), 1);
    @(posedge Clk);
    #1;
    chk("b2b_accept", 32'(CmdReady), 0);
    CmdValid = 1'b0;
    clear_mon();
    wait_done(lat);
    chk("b2b_write_lat", lat, exp_latency(OP_WRITE));
    chk("b2b_latch2", 32'(latch), 32'(tx2));
    lat_exp = tx2;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end

    // Reset asserted while bit 4 is being shifted
    @(negedge Clk);
    CmdOp = OP_WRITE;
    TxData = ~lat_exp;
    CmdValid = 1'b1;
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
    clear_mon();
    n = 0;
    while (sin_q.size() < 5 && n < 100) begin
      @(posedge Clk);
      n++;
    end
    chk("reach_bit4", sin_q.size(), 5);
    #1;
    Reset = 1'b1;
    #1;
    chk("abort_outs", 32'({Done, SClkP, SClkN, SEnable,
                            SUpdate, SReset, SIn}), 0);
    chk("abort_ready", 32'(CmdReady), 1);
    chk("abort_rx", 32'(RxData), 0);
    rx_exp = '0;
    done_cnt = 0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (8) @(negedge Clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_latch", 32'(latch), 32'(lat_exp));
    chk("abort_idle", 32'(CmdReady), 1);

    run_cmd(OP_XFER, 8'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_chain_master.md
Name: scan_chain_master

Overview:
On-chip master that sequences a generated scan chain (ReadSegment/WriteSegment segments) from a single system clock.
- Generates the non-overlapping two-phase scan clocks (SClkP/SClkN) plus SEnable, SUpdate and SReset.
- Serialises a parallel write word onto SIn and deserialises SOut into a parallel read word.
- Sits between a host/register interface and the scan chain's SIn/SOut pins; one command at a time via a valid/ready handshake.

Parameters:
ChainLength, 104, total scan chain bits (equals the chain's TotalLength define); must be >= 1
HalfPeriod, 2, system-clock cycles each scan clock phase (SClkP or SClkN) is held high; must be >= 1
ResetCycles, 4, system-clock cycles SReset is held high for a RESET command; must be >= 1

Ports:
Clk  input  1  system clock; all outputs registered on rising edge
Reset  input  1  asynchronous, active-high reset
CmdValid  input  1  command request
CmdReady  output  1  controller idle, accepts command
CmdOp  input  2  0=RESET, 1=WRITE (shift+update), 2=READ (capture+shift), 3=XFER (capture+shift+update)
TxData  input  ChainLength  word to shift in; sampled on command handshake
RxData  output  ChainLength  word shifted out
Done  output  1  one-cycle pulse when command completes
SClkP  output  1  scan clock phase P
SClkN  output  1  scan clock phase N
SEnable  output  1  1=shift, 0=capture/hold
SUpdate  output  1  config latch update strobe
SReset  output  1  scan chain reset
SIn  output  1  serial data to chain
SOut  input  1  serial data from chain

Behaviour:
- Reset values: CmdReady=1; Done, SClkP, SClkN, SEnable, SUpdate, SReset, SIn = 0; RxData = 0; FSM in IDLE.
- Handshake: a command is accepted when CmdValid && CmdReady. In the same edge, TxData is latched into the internal shift register and CmdReady drops. CmdReady returns to 1 in the cycle after Done. Requests while busy are ignored.
- Non-overlap invariant: SClkP and SClkN are never high in the same cycle. Every transition between them has at least one cycle with both low.
- States: IDLE, RST, CAP_P, CAP_G1, CAP_N, CAP_G2, SH_SETUP, SH_P, SH_MID, SH_N, UPD_G, UPD, DONE.
- RESET: RST holds SReset=1 for ResetCycles cycles, then DONE.
- Capture (READ/XFER only), with SEnable=0 throughout:
  - CAP_P: SClkP=1 for HalfPeriod cycles.
  - CAP_G1: 1 cycle, both clocks low.
  - CAP_N: SClkN=1 for HalfPeriod cycles.
  - CAP_G2: 1 cycle, both clocks low.
- Shift, with SEnable=1; for bit k = 0..ChainLength-1:
  - SH_SETUP (1 cycle): SIn <= shift register bit k (TxData[0] goes first); SOut is sampled into RxData[k].
  - SH_P: SClkP=1 for HalfPeriod cycles.
  - SH_MID: 1 cycle, both clocks low.
  - SH_N: SClkN=1 for HalfPeriod cycles.
  - Each bit costs 2*HalfPeriod+2 cycles.
  - The bit counter is clog2(ChainLength+1) wide; after bit ChainLength-1 the FSM leaves shift (no wrap).
- Update (WRITE/XFER only):
  - UPD_G: 1 cycle, SEnable=0.
  - UPD: SUpdate=1 for HalfPeriod cycles.
  - SIn stays at the last shifted bit.
- DONE: 1 cycle, Done=1, all scan clocks low, SEnable=0.
- Latency: WRITE Done occurs ChainLength*(2H+2)+H+1 cycles after the handshake edge (H=HalfPeriod). READ adds 2H+2 for capture; XFER has both.
- RxData is updated only by READ/XFER. It holds its value after Done until the next READ/XFER is accepted. RESET and WRITE leave RxData unchanged.
- Reset mid-operation: all outputs return asynchronously to reset values and the FSM goes to IDLE.
  - Chain shift contents are undefined afterwards.
  - Config latches are untouched unless SUpdate was already high.
  - No Done is generated for the aborted command.
- A single shared phase timer (counts 0..HalfPeriod-1, and 0..ResetCycles-1 in RST) is reloaded on every state entry.

Decomposition:
- Package scan_ctrl_pkg: CmdOp encoding constants (OP_RESET/OP_WRITE/OP_READ/OP_XFER) and the FSM state enum.
- Sub-module scan_phase_timer: loadable down-counter with terminal-count output; used for every timed state.

Test Plan:
- Bench overrides ChainLength=8, HalfPeriod=1, ResetCycles=3; a behavioural model of an 8-bit two-phase shift register with capture input and update latch is attached.
- RESET: SReset high exactly 3 cycles; Done 1 cycle later; CmdReady=0 throughout.
- WRITE TxData=8'hA5: SIn sequence 1,0,1,0,0,1,0,1; model latch=8'hA5 after SUpdate; Done exactly 8*4+1+1=34 cycles after the handshake edge.
- READ with model capture input 8'h3C: RxData=8'h3C at Done (bit order per model); latch unchanged; SUpdate never asserted.
- XFER TxData=8'hFF with capture 8'h00: RxData=8'h00, latch=8'hFF; protocol checker sees no SClkP/SClkN overlap and ≥1 gap cycle at every phase change.
- Back-to-back commands with CmdValid held: second accepted the cycle after Done; CmdValid during busy is ignored.
- Reset asserted mid-shift at bit 4: all outputs 0 immediately, CmdReady=1, no Done pulse; latch retains prior value.
